// File: rtl/division.sv
// Multi-cycle restoring divider: one quotient bit per clock, WIDTH clocks per operation.
// Define DIVISION_SIGNED_EN to add the signedOp port and two's-complement division.
module division #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] lhs,
    input  logic [WIDTH-1:0] rhs,
`ifdef DIVISION_SIGNED_EN
    input  logic             signedOp,
`endif
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             endSignal,
    output logic             divByZero,
    output logic [1:0]       state_dbg
);

    // Handshake: start is accepted on a rising edge whenever the FSM is not in WORK;
    // results are valid in the cycle where endSignal is high and hold until the next completion.

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, WORK = 2'd1, DONE = 2'd2} state_t;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dsr;
    logic [WIDTH-1:0] rem;
    logic             neg_q;
    logic             neg_r;

    logic             signed_op;
    logic             accept;
    logic             last;
    logic [WIDTH:0]   shifted;
    logic             ge;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] dvd_next;
    logic [WIDTH-1:0] lhs_mag;
    logic [WIDTH-1:0] rhs_mag;

`ifdef DIVISION_SIGNED_EN
    assign signed_op = signedOp;
`else
    assign signed_op = 1'b0;
`endif

    assign accept = start && (state != WORK);
    assign last   = (cnt == LAST);

    // Signed mode divides magnitudes; -2^(WIDTH-1) maps to itself, which is its correct unsigned magnitude.
    assign lhs_mag = (signed_op && lhs[WIDTH-1]) ? (~lhs + 1'b1) : lhs;
    assign rhs_mag = (signed_op && rhs[WIDTH-1]) ? (~rhs + 1'b1) : rhs;

    // The dividend register shifts out its MSB and shifts in the new quotient bit at the LSB.
    always_comb begin
        shifted  = {rem, dvd[WIDTH-1]};
        ge       = (shifted >= {1'b0, dsr});
        rem_next = ge ? WIDTH'(shifted - {1'b0, dsr}) : shifted[WIDTH-1:0];
        dvd_next = {dvd[WIDTH-2:0], ge};
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (rhs == '0) ? DONE : WORK;
            WORK:    if (last)  state_next = DONE;
            DONE:    if (start) state_next = (rhs == '0) ? DONE : WORK;
                     else       state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == WORK);
        state_dbg = state;
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            dvd       <= '0;
            dsr       <= '0;
            rem       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            endSignal <= 1'b0;
            divByZero <= 1'b0;
        end else begin
            endSignal <= 1'b0;
            if (accept) begin
                cnt <= '0;
                if (rhs == '0) begin
                    quotient  <= '1;
                    remainder <= lhs;
                    divByZero <= 1'b1;
                    endSignal <= 1'b1;
                end else begin
                    dvd       <= lhs_mag;
                    dsr       <= rhs_mag;
                    rem       <= '0;
                    neg_q     <= signed_op && (lhs[WIDTH-1] ^ rhs[WIDTH-1]);
                    neg_r     <= signed_op && lhs[WIDTH-1];
                    divByZero <= 1'b0;
                end
            end else if (state == WORK) begin
                cnt <= cnt + CW'(1);
                dvd <= dvd_next;
                rem <= rem_next;
                if (last) begin
                    quotient  <= neg_q ? (~dvd_next + 1'b1) : dvd_next;
                    remainder <= neg_r ? (~rem_next + 1'b1) : rem_next;
                    endSignal <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_division.sv
// Directed bench for division at WIDTH=32; signed vectors run only when DIVISION_SIGNED_EN is defined.
module tb_division;

    logic        Clk;
    logic        reset;
    logic        start;
    logic [31:0] lhs;
    logic [31:0] rhs;
`ifdef DIVISION_SIGNED_EN
    logic        signedOp;
`endif
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        busy;
    logic        endSignal;
    logic        divByZero;
    logic [1:0]  state_dbg;

    int n_total = 0;
    int n_pass  = 0;

    division #(.WIDTH(32)) dut (
        .Clk       (Clk),
        .reset     (reset),
        .start     (start),
        .lhs       (lhs),
        .rhs       (rhs),
`ifdef DIVISION_SIGNED_EN
        .signedOp  (signedOp),
`endif
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .endSignal (endSignal),
        .divByZero (divByZero),
        .state_dbg (state_dbg)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Drives one start pulse across a single rising edge (E0); returns at the following negedge.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        @(negedge Clk);
        lhs   = a;
        rhs   = b;
`ifdef DIVISION_SIGNED_EN
        signedOp = 1'b0;
`endif
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
    endtask

`ifdef DIVISION_SIGNED_EN
    task automatic start_sop(input logic [31:0] a, input logic [31:0] b);
        @(negedge Clk);
        lhs      = a;
        rhs      = b;
        signedOp = 1'b1;
        start    = 1'b1;
        @(negedge Clk);
        start    = 1'b0;
    endtask
`endif

    // Called at the negedge after E0; returns at the negedge after E32.
    // inject_at > 0 raises a 9/3 start for one edge while the divider is working.
    task automatic wait_done(input string tag, input int inject_at);
        int bad;
        bad = 0;
        for (int i = 1; i <= 31; i++) begin
            @(negedge Clk);
            if (!busy || endSignal) bad++;
            if (i == inject_at) begin
                start = 1'b1;
                lhs   = 32'd9;
                rhs   = 32'd3;
            end else begin
                start = 1'b0;
            end
        end
        @(negedge Clk);
        start = 1'b0;
        check({tag, " latency"}, 32'(bad), 32'd0);
        check({tag, " end"}, {31'd0, endSignal}, 32'd1);
        check({tag, " busy_done"}, {31'd0, busy}, 32'd0);
        check({tag, " state_done"}, {30'd0, state_dbg}, 32'd2);
    endtask

    initial begin
        int bad;
        reset = 1'b1;
        start = 1'b0;
        lhs   = '0;
        rhs   = '0;
`ifdef DIVISION_SIGNED_EN
        signedOp = 1'b0;
`endif
        repeat (2) @(negedge Clk);
        check("rst quotient", quotient, 32'd0);
        check("rst remainder", remainder, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst end", {31'd0, endSignal}, 32'd0);
        check("rst dbz", {31'd0, divByZero}, 32'd0);
        check("rst state", {30'd0, state_dbg}, 32'd0);
        reset = 1'b0;

        // 100 / 7 = 14 r 2
        start_op(32'd100, 32'd7);
        check("u100 busy_e0", {31'd0, busy}, 32'd1);
        check("u100 end_e0", {31'd0, endSignal}, 32'd0);
        check("u100 q_hold", quotient, 32'd0);
        wait_done("u100", 0);
        check("u100 quotient", quotient, 32'd14);
        check("u100 remainder", remainder, 32'd2);
        check("u100 dbz", {31'd0, divByZero}, 32'd0);
        @(negedge Clk);
        check("u100 end_pulse", {31'd0, endSignal}, 32'd0);
        check("u100 idle", {30'd0, state_dbg}, 32'd0);
        check("u100 q_keep", quotient, 32'd14);

        // 5 / 0: immediate completion, no WORK
        start_op(32'd5, 32'd0);
        check("dbz end", {31'd0, endSignal}, 32'd1);
        check("dbz busy", {31'd0, busy}, 32'd0);
        check("dbz quotient", quotient, 32'hFFFF_FFFF);
        check("dbz remainder", remainder, 32'd5);
        check("dbz flag", {31'd0, divByZero}, 32'd1);
        @(negedge Clk);
        check("dbz end_pulse", {31'd0, endSignal}, 32'd0);
        check("dbz busy2", {31'd0, busy}, 32'd0);
        check("dbz flag_hold", {31'd0, divByZero}, 32'd1);

        // Start while working is ignored, then back-to-back start from DONE
        start_op(32'd100, 32'd7);
        check("ign dbz_clear", {31'd0, divByZero}, 32'd0);
        check("ign q_hold", quotient, 32'hFFFF_FFFF);
        wait_done("ign", 5);
        check("ign quotient", quotient, 32'd14);
        check("ign remainder", remainder, 32'd2);
        lhs   = 32'hFFFF_FFFF;
        rhs   = 32'd1;
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        check("b2b busy", {31'd0, busy}, 32'd1);
        check("b2b q_hold", quotient, 32'd14);
        wait_done("b2b", 0);
        check("b2b quotient", quotient, 32'hFFFF_FFFF);
        check("b2b remainder", remainder, 32'd0);

        // Reset after 10 iterations abandons the operation
        start_op(32'd100, 32'd7);
        repeat (10) @(negedge Clk);
        reset = 1'b1;
        #1;
        check("rmid quotient", quotient, 32'd0);
        check("rmid remainder", remainder, 32'd0);
        check("rmid busy", {31'd0, busy}, 32'd0);
        check("rmid end", {31'd0, endSignal}, 32'd0);
        check("rmid state", {30'd0, state_dbg}, 32'd0);
        @(negedge Clk);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (endSignal || busy) bad++;
        end
        check("rmid quiet", 32'(bad), 32'd0);
        start_op(32'd20, 32'd6);
        wait_done("u20", 0);
        check("u20 quotient", quotient, 32'd3);
        check("u20 remainder", remainder, 32'd2);

`ifdef DIVISION_SIGNED_EN
        start_sop(32'hFFFF_FFF9, 32'd2);
        wait_done("sm7", 0);
        check("sm7 quotient", quotient, 32'hFFFF_FFFD);
        check("sm7 remainder", remainder, 32'hFFFF_FFFF);
        start_sop(32'd7, 32'hFFFF_FFFE);
        wait_done("s7m2", 0);
        check("s7m2 quotient", quotient, 32'hFFFF_FFFD);
        check("s7m2 remainder", remainder, 32'd1);
        start_sop(32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("smin", 0);
        check("smin quotient", quotient, 32'h8000_0000);
        check("smin remainder", remainder, 32'd0);
        start_sop(32'hFFFF_FFF9, 32'd0);
        check("sdbz quotient", quotient, 32'hFFFF_FFFF);
        check("sdbz remainder", remainder, 32'hFFFF_FFF9);
        check("sdbz flag", {31'd0, divByZero}, 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
